// File: rtl/src_control_unit_pkg.sv
// rtl/src_control_unit_pkg.sv - SRC control unit types; SRC_SINGLE_STEP_EN adds the PAUSE state
package src_ctrl_pkg;

  typedef enum logic [4:0] {
    OP_NOP  = 5'd0,
    OP_LD   = 5'd1,
    OP_ST   = 5'd3,
    OP_LA   = 5'd5,
    OP_BR   = 5'd8,
    OP_ADD  = 5'd12,
    OP_ADDI = 5'd13,
    OP_SUB  = 5'd14,
    OP_NEG  = 5'd15,
    OP_AND  = 5'd20,
    OP_ANDI = 5'd21,
    OP_OR   = 5'd22,
    OP_ORI  = 5'd23,
    OP_NOT  = 5'd24,
    OP_STOP = 5'd31
  } opcode_t;

  typedef enum logic [3:0] {
    ALU_PASS, ALU_ADD, ALU_SUB, ALU_NEG, ALU_AND, ALU_OR, ALU_NOT, ALU_INC4
  } alu_op_t;

  typedef enum logic [3:0] {
    ST_IDLE, ST_T0, ST_T1, ST_T2, ST_T3, ST_T4, ST_T5, ST_T6, ST_T7, ST_HALT
`ifdef SRC_SINGLE_STEP_EN
    , ST_PAUSE
`endif
  } state_t;

  typedef enum logic [3:0] {
    CLS_NOP, CLS_MEM_LD, CLS_MEM_ST, CLS_LA, CLS_ALU_RR, CLS_ALU_RI,
    CLS_ALU_UN, CLS_BR, CLS_STOP, CLS_ILLEGAL
  } iclass_t;

  typedef struct packed {
    logic    pc_out;
    logic    pc_in;
    logic    ma_in;
    logic    md_out;
    logic    md_in;
    logic    ir_in;
    logic    c1_out;
    logic    c2_out;
    logic    gra;
    logic    grb;
    logic    grc;
    logic    r_out;
    logic    r_in;
    logic    ba_out;
    logic    a_in;
    logic    c_in;
    logic    c_out;
    alu_op_t alu_op;
    logic    con_in;
    logic    mem_read;
    logic    mem_write;
  } ctrl_t;

endpackage

// File: rtl/src_control_unit_if.sv
// rtl/src_control_unit_if.sv - control unit <-> datapath/IR/memory signal bundle
interface src_control_unit_if;
  import src_ctrl_pkg::*;

  logic       run;
  logic [4:0] opcode;
  logic       con;
  logic       mem_done;
`ifdef SRC_SINGLE_STEP_EN
  logic       step;
`endif
  logic pc_out, pc_in, ma_in, md_out, md_in, ir_in;
  logic c1_out, c2_out;
  logic gra, grb, grc, r_out, r_in, ba_out;
  logic a_in, c_in, c_out;
  alu_op_t alu_op;
  logic con_in, mem_read, mem_write;
  logic halted, err;

  modport master (
    input  run, opcode, con, mem_done,
`ifdef SRC_SINGLE_STEP_EN
    input  step,
`endif
    output pc_out, pc_in, ma_in, md_out, md_in, ir_in, c1_out, c2_out,
    output gra, grb, grc, r_out, r_in, ba_out, a_in, c_in, c_out,
    output alu_op, con_in, mem_read, mem_write, halted, err
  );

  modport slave (
    output run, opcode, con, mem_done,
`ifdef SRC_SINGLE_STEP_EN
    output step,
`endif
    input  pc_out, pc_in, ma_in, md_out, md_in, ir_in, c1_out, c2_out,
    input  gra, grb, grc, r_out, r_in, ba_out, a_in, c_in, c_out,
    input  alu_op, con_in, mem_read, mem_write, halted, err
  );

endinterface

// File: rtl/src_control_unit_opcode_decoder.sv
// rtl/src_control_unit_opcode_decoder.sv - opcode to instruction class and ALU operation
module src_opcode_decoder
  import src_ctrl_pkg::*;
(
  input  logic [4:0] opcode_i,
  output iclass_t    cls_o,
  output alu_op_t    alu_op_o
);

  always_comb begin
    cls_o    = CLS_ILLEGAL;
    alu_op_o = ALU_PASS;
    case (opcode_i)
      OP_NOP:  cls_o = CLS_NOP;
      OP_LD:   begin cls_o = CLS_MEM_LD; alu_op_o = ALU_ADD; end
      OP_ST:   begin cls_o = CLS_MEM_ST; alu_op_o = ALU_ADD; end
      OP_LA:   begin cls_o = CLS_LA;     alu_op_o = ALU_ADD; end
      OP_BR:   cls_o = CLS_BR;
      OP_ADD:  begin cls_o = CLS_ALU_RR; alu_op_o = ALU_ADD; end
      OP_SUB:  begin cls_o = CLS_ALU_RR; alu_op_o = ALU_SUB; end
      OP_AND:  begin cls_o = CLS_ALU_RR; alu_op_o = ALU_AND; end
      OP_OR:   begin cls_o = CLS_ALU_RR; alu_op_o = ALU_OR;  end
      OP_ADDI: begin cls_o = CLS_ALU_RI; alu_op_o = ALU_ADD; end
      OP_ANDI: begin cls_o = CLS_ALU_RI; alu_op_o = ALU_AND; end
      OP_ORI:  begin cls_o = CLS_ALU_RI; alu_op_o = ALU_OR;  end
      OP_NEG:  begin cls_o = CLS_ALU_UN; alu_op_o = ALU_NEG; end
      OP_NOT:  begin cls_o = CLS_ALU_UN; alu_op_o = ALU_NOT; end
      OP_STOP: cls_o = CLS_STOP;
      default: cls_o = CLS_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/src_control_unit.sv
// rtl/src_control_unit.sv - SRC hardwired T-step sequencer with registered strobes
// SRC_SINGLE_STEP_EN adds a step input and a PAUSE state between instructions.
module src_control_unit
  import src_ctrl_pkg::*;
#(
  parameter int W            = 32,
  parameter int MEM_WAIT_MAX = 15
) (
  input logic               clk,
  input logic               rst,
  src_control_unit_if.master bus
);

  localparam logic [3:0]   WAIT_MAX = 4'(MEM_WAIT_MAX);
  localparam logic [W-1:0] INC4_K   = W'(4);

  state_t     state_q, state_d, end_state;
  iclass_t    cls_q, cls_d, dec_cls;
  alu_op_t    aop_q, aop_d, dec_aop;
  logic [3:0] wait_q, wait_d;
  logic       err_q, err_d;
  logic       halted_q;
  logic       br_pc_q;
  logic       mem_wait;
  ctrl_t      ctrl_q;

  src_opcode_decoder u_dec (
    .opcode_i (bus.opcode),
    .cls_o    (dec_cls),
    .alu_op_o (dec_aop)
  );

  function automatic ctrl_t ctrl_for(input state_t s, input iclass_t c, input alu_op_t op);
    ctrl_t k;
    k = '0;
    case (s)
      ST_T0: begin k.pc_out = 1'b1; k.ma_in = 1'b1; k.alu_op = ALU_INC4; k.c_in = 1'b1; end
      ST_T1: begin k.mem_read = 1'b1; k.c_out = 1'b1; k.pc_in = 1'b1; end
      ST_T2: begin k.md_out = 1'b1; k.ir_in = 1'b1; end
      ST_T3: case (c)
        CLS_MEM_LD, CLS_MEM_ST, CLS_LA: begin k.grb = 1'b1; k.ba_out = 1'b1; k.a_in = 1'b1; end
        CLS_ALU_RR, CLS_ALU_RI:         begin k.grb = 1'b1; k.r_out = 1'b1; k.a_in = 1'b1; end
        CLS_ALU_UN: begin k.grc = 1'b1; k.r_out = 1'b1; k.alu_op = op; k.c_in = 1'b1; end
        CLS_BR:     begin k.grc = 1'b1; k.r_out = 1'b1; k.con_in = 1'b1; end
        default: ;
      endcase
      ST_T4: case (c)
        CLS_MEM_LD, CLS_MEM_ST, CLS_LA: begin k.c2_out = 1'b1; k.alu_op = ALU_ADD; k.c_in = 1'b1; end
        CLS_ALU_RR: begin k.grc = 1'b1; k.r_out = 1'b1; k.alu_op = op; k.c_in = 1'b1; end
        CLS_ALU_RI: begin k.c2_out = 1'b1; k.alu_op = op; k.c_in = 1'b1; end
        CLS_ALU_UN: begin k.c_out = 1'b1; k.gra = 1'b1; k.r_in = 1'b1; end
        CLS_BR:     begin k.grb = 1'b1; k.r_out = 1'b1; end
        default: ;
      endcase
      ST_T5: case (c)
        CLS_MEM_LD, CLS_MEM_ST:         begin k.c_out = 1'b1; k.ma_in = 1'b1; end
        CLS_LA, CLS_ALU_RR, CLS_ALU_RI: begin k.c_out = 1'b1; k.gra = 1'b1; k.r_in = 1'b1; end
        default: ;
      endcase
      ST_T6: case (c)
        CLS_MEM_LD: k.mem_read = 1'b1;
        CLS_MEM_ST: begin k.gra = 1'b1; k.r_out = 1'b1; k.md_in = 1'b1; end
        default: ;
      endcase
      ST_T7: case (c)
        CLS_MEM_LD: begin k.md_out = 1'b1; k.gra = 1'b1; k.r_in = 1'b1; end
        CLS_MEM_ST: k.mem_write = 1'b1;
        default: ;
      endcase
      default: ;
    endcase
    return k;
  endfunction

`ifdef SRC_SINGLE_STEP_EN
  logic step_q;
  assign end_state = bus.run ? ST_PAUSE : ST_IDLE;
`else
  assign end_state = bus.run ? ST_T0 : ST_IDLE;
`endif

  assign mem_wait = (state_q == ST_T1) ||
                    (state_q == ST_T6 && cls_q == CLS_MEM_LD) ||
                    (state_q == ST_T7 && cls_q == CLS_MEM_ST);

  always_comb begin
    state_d = state_q;
    cls_d   = cls_q;
    aop_d   = aop_q;
    wait_d  = wait_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: if (bus.run) state_d = ST_T0;
      ST_T0:   state_d = ST_T1;
      ST_T1:   state_d = ST_T2;
      ST_T2: begin
        state_d = ST_T3;
        cls_d   = dec_cls;
        aop_d   = dec_aop;
      end
      ST_T3: case (cls_q)
        CLS_NOP:     state_d = end_state;
        CLS_STOP:    state_d = ST_HALT;
        CLS_ILLEGAL: begin state_d = ST_HALT; err_d = 1'b1; end
        default:     state_d = ST_T4;
      endcase
      ST_T4:   state_d = (cls_q == CLS_ALU_UN || cls_q == CLS_BR) ? end_state : ST_T5;
      ST_T5:   state_d = (cls_q == CLS_MEM_LD || cls_q == CLS_MEM_ST) ? ST_T6 : end_state;
      ST_T6:   state_d = ST_T7;
      ST_T7:   state_d = end_state;
      ST_HALT: state_d = ST_HALT;
`ifdef SRC_SINGLE_STEP_EN
      ST_PAUSE: begin
        if (!bus.run)                  state_d = ST_IDLE;
        else if (bus.step && !step_q)  state_d = ST_T0;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
    // A wait step overrides the normal advance until mem_done or timeout.
    if (mem_wait) begin
      if (bus.mem_done) begin
        wait_d = 4'd0;
      end else if (wait_q == WAIT_MAX) begin
        state_d = ST_HALT;
        err_d   = 1'b1;
        wait_d  = 4'd0;
      end else begin
        state_d = state_q;
        wait_d  = wait_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      cls_q    <= CLS_NOP;
      aop_q    <= ALU_PASS;
      wait_q   <= 4'd0;
      err_q    <= 1'b0;
      halted_q <= 1'b0;
      br_pc_q  <= 1'b0;
      ctrl_q   <= '0;
`ifdef SRC_SINGLE_STEP_EN
      step_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cls_q    <= cls_d;
      aop_q    <= aop_d;
      wait_q   <= wait_d;
      err_q    <= err_d;
      halted_q <= (state_d == ST_HALT);
      br_pc_q  <= (state_d == ST_T4) && (cls_d == CLS_BR);
      ctrl_q   <= ctrl_for(state_d, cls_d, aop_d);
`ifdef SRC_SINGLE_STEP_EN
      step_q   <= bus.step;
`endif
    end
  end

  assign bus.pc_out    = ctrl_q.pc_out;
  // Branch target load follows the live CON flag, which is only valid once T3's con_in has landed.
  assign bus.pc_in     = ctrl_q.pc_in | (br_pc_q & bus.con);
  assign bus.ma_in     = ctrl_q.ma_in;
  assign bus.md_out    = ctrl_q.md_out;
  assign bus.md_in     = ctrl_q.md_in;
  assign bus.ir_in     = ctrl_q.ir_in;
  assign bus.c1_out    = ctrl_q.c1_out;
  assign bus.c2_out    = ctrl_q.c2_out;
  assign bus.gra       = ctrl_q.gra;
  assign bus.grb       = ctrl_q.grb;
  assign bus.grc       = ctrl_q.grc;
  assign bus.r_out     = ctrl_q.r_out;
  assign bus.r_in      = ctrl_q.r_in;
  assign bus.ba_out    = ctrl_q.ba_out;
  assign bus.a_in      = ctrl_q.a_in;
  assign bus.c_in      = ctrl_q.c_in;
  assign bus.c_out     = ctrl_q.c_out;
  assign bus.alu_op    = ctrl_q.alu_op;
  assign bus.con_in    = ctrl_q.con_in;
  assign bus.mem_read  = ctrl_q.mem_read;
  assign bus.mem_write = ctrl_q.mem_write;
  assign bus.halted    = halted_q;
  assign bus.err       = err_q;

  logic [6:0] bus_drivers;
  assign bus_drivers = {ctrl_q.r_out, ctrl_q.pc_out, ctrl_q.md_out, ctrl_q.c1_out,
                        ctrl_q.c2_out, ctrl_q.c_out, ctrl_q.ba_out};

  a_single_driver: assert property (@(posedge clk) disable iff (!rst) $onehot0(bus_drivers));
  a_inc4: assert property (@(posedge clk) disable iff (!rst)
    (ctrl_q.alu_op == ALU_INC4) |-> (ctrl_q.pc_out && ctrl_q.c_in && INC4_K[2]));

endmodule
